data_mem_responder: RTL and testbench

//  Memory-side responder for the CPU data-memory interface: read/write enable, byte address,

---
 rtl/data_mem_pkg.sv | 39 +++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/data_mem_responder.sv | 156 +++++++++++++++
 tb/tb_data_mem_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// ============================================================================
// data_mem_pkg : shared encodings and access-legality check for the responder
// Rev 1.0
// ============================================================================
`default_nettype none

package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic access_illegal(
        input logic       rd,
        input logic       wr,
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        logic bad;
        bad = rd & wr;
        case (size)
            SZ_BYTE: bad = bad;
            SZ_HALF: bad = bad | addr_lo[0];
            SZ_WORD: bad = bad | (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// mem_lane_align : store byte-enables/lane replication, load lane extract+extend
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        is_unsign_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
        w_byte  = rword_i[{addr_lo_i, 3'b000} +: 8];
        w_half  = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{~is_unsign_i & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{~is_unsign_i & w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0;
                rdata_o = 32'h0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder : byte-addressable word RAM behind the CPU data interface
// Rev 1.0
// ============================================================================
`default_nettype none

module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_read_i,
    input  logic        en_write_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic        is_unsign_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ready_o,
    output logic        err_o
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            rd_q, wr_q, uns_q;
    logic [1:0]      size_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            w_idle, w_req, w_enter_resp, w_illegal, w_commit;
    logic            w_cur_rd, w_cur_wr, w_cur_uns;
    logic [1:0]      w_cur_size;
    logic [AW+1:0]   w_cur_addr;
    logic [31:0]     w_cur_wdata;
    logic [AW-1:0]   w_idx;
    logic [3:0]      w_be;
    logic [31:0]     w_st_data, w_ld_data, w_rword;
    logic            unused_addr_hi;

    assign unused_addr_hi = ^addr_i[31:AW+2];

    // With zero wait states the RAM is accessed on the capture edge itself,
    // so the access fields come straight from the ports while idle.
    assign w_idle      = (state_q == ST_IDLE);
    assign w_req       = en_read_i | en_write_i;
    assign w_cur_rd    = w_idle ? en_read_i          : rd_q;
    assign w_cur_wr    = w_idle ? en_write_i         : wr_q;
    assign w_cur_uns   = w_idle ? is_unsign_i        : uns_q;
    assign w_cur_size  = w_idle ? size_i             : size_q;
    assign w_cur_addr  = w_idle ? addr_i[AW+1:0]     : addr_q;
    assign w_cur_wdata = w_idle ? wdata_i            : wdata_q;
    assign w_idx       = w_cur_addr[AW+1:2];
    assign w_illegal   = access_illegal(w_cur_rd, w_cur_wr, w_cur_size, w_cur_addr[1:0]);
    assign w_commit    = w_enter_resp & w_cur_wr & ~w_illegal;
    assign w_rword     = mem_q[w_idx];

    mem_lane_align u_align (
        .size_i      (w_cur_size),
        .addr_lo_i   (w_cur_addr[1:0]),
        .is_unsign_i (w_cur_uns),
        .wdata_i     (w_cur_wdata),
        .rword_i     (w_rword),
        .be_o        (w_be),
        .wdata_o     (w_st_data),
        .rdata_o     (w_ld_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        w_enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d      = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_idle && w_req) begin
                rd_q    <= en_read_i;
                wr_q    <= en_write_i;
                uns_q   <= is_unsign_i;
                size_q  <= size_i;
                addr_q  <= addr_i[AW+1:0];
                wdata_q <= wdata_i;
            end
            if (w_enter_resp) begin
                err_q   <= w_illegal;
                rdata_q <= (w_cur_rd && !w_illegal) ? w_ld_data : 32'h0;
            end else begin
                err_q   <= 1'b0;
                rdata_q <= 32'h0;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    mem_q[w_idx][8*k +: 8] <= w_st_data[8*k +: 8];
                end
            end
        end
    end

    assign ready_o = (state_q == ST_RESP);
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// tb_data_mem_responder : two responders (0 and 1 wait states) vs array model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int WAITS [2] = '{0, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_read [2];
    logic        en_write [2];
    logic        is_unsign [2];
    logic        ready [2];
    logic        err [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [1:0]  size [2];

    logic [31:0] mem_m [2][1024];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en_read_i(en_read[0]), .en_write_i(en_write[0]),
        .addr_i(addr[0]), .size_i(size[0]), .is_unsign_i(is_unsign[0]), .wdata_i(wdata[0]),
        .rdata_o(rdata[0]), .ready_o(ready[0]), .err_o(err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en_read_i(en_read[1]), .en_write_i(en_write[1]),
        .addr_i(addr[1]), .size_i(size[1]), .is_unsign_i(is_unsign[1]), .wdata_i(wdata[1]),
        .rdata_o(rdata[1]), .ready_o(ready[1]), .err_o(err[1])
    );

    // Reference: little-endian word array indexed by addr[11:2].
    function automatic void model(input int d, input bit rd, input bit wr,
                                  input logic [31:0] a, input logic [1:0] sz, input bit uns,
                                  input logic [31:0] wd,
                                  output logic [31:0] er, output logic ee);
        int unsigned idx, lo, sh;
        logic [31:0] w, v, mask;
        idx = int'(a[11:2]);
        lo  = int'(a[1:0]);
        ee  = (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && (lo % 2) != 0) || (sz == 2'd2 && lo != 0);
        er  = 32'h0;
        if (ee) return;
        w = mem_m[d][idx];
        if (sz == 2'd0) begin
            sh = 8 * lo;
            mask = 32'hFF << sh;
        end else if (sz == 2'd1) begin
            sh = 16 * (lo / 2);
            mask = 32'hFFFF << sh;
        end else begin
            sh = 0;
            mask = 32'hFFFF_FFFF;
        end
        if (wr) begin
            mem_m[d][idx] = (w & ~mask) | ((wd << sh) & mask);
        end else begin
            v = (w & mask) >> sh;
            if (!uns && sz == 2'd0 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
            if (!uns && sz == 2'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
            er = v;
        end
    endfunction

    task automatic access(input int d, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [1:0] sz, input bit uns, input logic [31:0] wd,
                          output logic [31:0] got_rd, output logic got_err, output int lat,
                          output logic rdy_after);
        @(negedge clk);
        en_read[d] = rd; en_write[d] = wr; addr[d] = a; size[d] = sz;
        is_unsign[d] = uns; wdata[d] = wd;
        @(posedge clk);
        lat = 0;
        #1;
        while (ready[d] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got_rd = rdata[d];
        got_err = err[d];
        en_read[d] = 1'b0; en_write[d] = 1'b0;
        @(posedge clk);
        #1;
        rdy_after = ready[d];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ready[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d: ready=%b err=%b rdata=%h, want 0/0/0", d, ready[d], err[d], rdata[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic init_mem();
        logic [31:0] r, er; logic e, ee, ra; int lat;
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++) begin
                model(d, 1'b0, 1'b1, 32'(w * 4), 2'd2, 1'b0, 32'h0, er, ee);
                access(d, 1'b0, 1'b1, 32'(w * 4), 2'd2, 1'b0, 32'h0, r, e, lat, ra);
            end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] r, er; logic e, ee, ra; int lat;
        // Store aborted while waiting must never land in RAM.
        @(negedge clk);
        en_write[1] = 1'b1; en_read[1] = 1'b0; addr[1] = 32'h40; size[1] = 2'd2; wdata[1] = 32'h1234_5678;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        en_write[1] = 1'b0;
        #1;
        checks++;
        if (ready[1] !== 1'b0 || err[1] !== 1'b0 || rdata[1] !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_wait: ready=%b err=%b rdata=%h, want 0/0/0", ready[1], err[1], rdata[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        access(1, 1'b1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, r, e, lat, ra);
        model(1, 1'b1, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, er, ee);
        checks++;
        if (r !== 32'h0 || er !== 32'h0) begin
            errors++;
            $display("FAIL reset_store_dropped: rdata=%h, want 00000000", r);
        end
        // Reset while a load response is being presented clears it at once.
        model(0, 1'b0, 1'b1, 32'h44, 2'd2, 1'b0, 32'h5A5A_5A5A, er, ee);
        access(0, 1'b0, 1'b1, 32'h44, 2'd2, 1'b0, 32'h5A5A_5A5A, r, e, lat, ra);
        @(negedge clk);
        en_read[0] = 1'b1; addr[0] = 32'h44; size[0] = 2'd2;
        @(posedge clk);
        #1;
        checks++;
        if (ready[0] !== 1'b1 || rdata[0] !== 32'h5A5A_5A5A) begin
            errors++;
            $display("FAIL resp_before_reset: ready=%b rdata=%h, want 1/5a5a5a5a", ready[0], rdata[0]);
        end
        #1;
        rst_n = 1'b0;
        en_read[0] = 1'b0;
        #1;
        checks++;
        if (ready[0] !== 1'b0 || err[0] !== 1'b0 || rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_resp: ready=%b err=%b rdata=%h, want 0/0/0", ready[0], err[0], rdata[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] r; logic e, ra; int lat;
        access(1, 1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, r, e, lat, ra);
        mem_m[1][4] = 32'hDEAD_BEEF;
        checks++;
        if (lat !== 1 || e !== 1'b0 || ra !== 1'b0) begin
            errors++;
            $display("FAIL word_store: lat=%0d err=%b ready_after=%b, want 1/0/0", lat, e, ra);
        end
        access(1, 1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, r, e, lat, ra);
        checks++;
        if (lat !== 1 || e !== 1'b0 || r !== 32'hDEAD_BEEF || ra !== 1'b0) begin
            errors++;
            $display("FAIL word_load: lat=%0d err=%b rdata=%h, want 1/0/deadbeef", lat, e, r);
        end
    endtask

    task automatic test_byte();
        logic [31:0] r; logic e, ra; int lat;
        access(1, 1'b0, 1'b1, 32'h10, 2'd2, 1'b0, 32'h0, r, e, lat, ra);
        access(1, 1'b0, 1'b1, 32'h13, 2'd0, 1'b0, 32'h0000_0080, r, e, lat, ra);
        mem_m[1][4] = 32'h8000_0000;
        access(1, 1'b1, 1'b0, 32'h13, 2'd0, 1'b0, 32'h0, r, e, lat, ra);
        checks++;
        if (r !== 32'hFFFF_FF80 || e !== 1'b0) begin
            errors++;
            $display("FAIL byte_load_signed: rdata=%h err=%b, want ffffff80/0", r, e);
        end
        access(1, 1'b1, 1'b0, 32'h13, 2'd0, 1'b1, 32'h0, r, e, lat, ra);
        checks++;
        if (r !== 32'h0000_0080 || e !== 1'b0) begin
            errors++;
            $display("FAIL byte_load_unsigned: rdata=%h err=%b, want 00000080/0", r, e);
        end
        access(1, 1'b1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, r, e, lat, ra);
        checks++;
        if (r !== 32'h8000_0000) begin
            errors++;
            $display("FAIL byte_word_view: rdata=%h, want 80000000", r);
        end
    endtask

    task automatic test_half();
        logic [31:0] r; logic e, ra; int lat;
        access(1, 1'b0, 1'b1, 32'h20, 2'd2, 1'b0, 32'h1111_2222, r, e, lat, ra);
        access(1, 1'b0, 1'b1, 32'h22, 2'd1, 1'b0, 32'h0000_A5C3, r, e, lat, ra);
        mem_m[1][8] = 32'hA5C3_2222;
        access(1, 1'b1, 1'b0, 32'h22, 2'd1, 1'b0, 32'h0, r, e, lat, ra);
        checks++;
        if (r !== 32'hFFFF_A5C3 || e !== 1'b0) begin
            errors++;
            $display("FAIL half_load_signed: rdata=%h err=%b, want ffffa5c3/0", r, e);
        end
        access(1, 1'b1, 1'b0, 32'h20, 2'd1, 1'b1, 32'h0, r, e, lat, ra);
        checks++;
        if (r !== 32'h0000_2222) begin
            errors++;
            $display("FAIL half_lower_kept: rdata=%h, want 00002222", r);
        end
    endtask

    task automatic test_reject();
        logic [31:0] r; logic e, ra; int lat;
        logic [31:0] ta [4] = '{32'h11, 32'h21, 32'h20, 32'h20};
        logic [1:0]  ts [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
        bit          trd [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        bit          twr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            access(1, trd[i], twr[i], ta[i], ts[i], 1'b0, 32'hFFFF_BEEF, r, e, lat, ra);
            checks++;
            if (e !== 1'b1 || r !== 32'h0 || lat !== 1) begin
                errors++;
                $display("FAIL reject_%0d: err=%b rdata=%h lat=%0d, want 1/00000000/1", i, e, r, lat);
            end
        end
        access(1, 1'b1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, r, e, lat, ra);
        checks++;
        if (r !== 32'hA5C3_2222 || e !== 1'b0) begin
            errors++;
            $display("FAIL reject_ram_intact: rdata=%h, want a5c32222", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        logic [31:0] r, er; logic e, ee, ra; int lat, cyc, last, n;
        for (int i = 0; i < 4; i++) vals[i] = $urandom;
        @(negedge clk);
        en_write[0] = 1'b1; en_read[0] = 1'b0; size[0] = 2'd2; addr[0] = 32'h80; wdata[0] = vals[0];
        cyc = 0; last = 0; n = 0;
        while (n < 4 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ready[0] === 1'b1) begin
                if (n > 0) begin
                    checks++;
                    if (cyc - last != 2) begin
                        errors++;
                        $display("FAIL b2b_spacing_%0d: gap=%0d cycles, want 2", n, cyc - last);
                    end
                end
                model(0, 1'b0, 1'b1, 32'(32'h80 + 4 * n), 2'd2, 1'b0, vals[n], er, ee);
                last = cyc;
                n++;
                if (n < 4) begin
                    addr[0] = 32'(32'h80 + 4 * n); wdata[0] = vals[n];
                end else begin
                    en_write[0] = 1'b0;
                end
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL b2b_timeout: completed=%0d, want 4", n);
        end
        en_write[0] = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            access(0, 1'b1, 1'b0, 32'(32'h8000_0080 + 4 * i), 2'd2, 1'b0, 32'h0, r, e, lat, ra);
            checks++;
            if (r !== vals[i] || lat !== 0) begin
                errors++;
                $display("FAIL b2b_readback_%0d: rdata=%h lat=%0d, want %h/0", i, r, lat, vals[i]);
            end
        end
        access(0, 1'b0, 1'b1, 32'h1000, 2'd2, 1'b0, 32'hCAFE_F00D, r, e, lat, ra);
        model(0, 1'b0, 1'b1, 32'h1000, 2'd2, 1'b0, 32'hCAFE_F00D, er, ee);
        access(0, 1'b1, 1'b0, 32'h0000, 2'd2, 1'b0, 32'h0, r, e, lat, ra);
        checks++;
        if (r !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL alias_0x1000: rdata=%h, want cafef00d", r);
        end
    endtask

    task automatic test_random(input int d, input int n);
        logic [31:0] r, er, rnd, a, wd; logic e, ee, ra; int lat, k;
        bit rd, wr, uns; logic [1:0] sz;
        for (int i = 0; i < n; i++) begin
            rnd = $urandom;
            a   = {rnd[31:12], 4'b0000, rnd[7:0]};
            k   = $urandom_range(0, 9);
            rd  = (k <= 4);
            wr  = (k == 0) || (k >= 5);
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            model(d, rd, wr, a, sz, uns, wd, er, ee);
            access(d, rd, wr, a, sz, uns, wd, r, e, lat, ra);
            checks++;
            if (r !== er || e !== ee || lat !== WAITS[d] || ra !== 1'b0) begin
                errors++;
                $display("FAIL random_dut%0d_%0d: a=%h rd=%b wr=%b sz=%0d got rdata=%h err=%b lat=%0d rdy_after=%b, want %h/%b/%0d/0",
                         d, i, a, rd, wr, sz, r, e, lat, ra, er, ee, WAITS[d]);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            en_read[d] = 1'b0; en_write[d] = 1'b0; is_unsign[d] = 1'b0;
            addr[d] = 32'h0; wdata[d] = 32'h0; size[d] = 2'd0;
        end
        test_reset();
        init_mem();
        test_reset_mid_access();
        test_word();
        test_byte();
        test_half();
        test_reject();
        test_back_to_back();
        test_random(0, 80);
        test_random(1, 80);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
